// File: rtl/button_conditioner.sv
// button_conditioner
// Conditions raw front-panel push-buttons for the clock/alarm top level.
// Each channel is fully independent and contains a 2-FF synchronizer, a
// counter-based debouncer, registered press/release pulses and, where
// enabled by REPEAT_MASK, a hold-to-auto-repeat pulse generator.
module button_conditioner #(
    parameter int unsigned        NUM_BTN             = 4,
    parameter int unsigned        DEBOUNCE_CYCLES     = 1_000_000,
    parameter int unsigned        REPEAT_DELAY_CYCLES = 50_000_000,
    parameter int unsigned        REPEAT_RATE_CYCLES  = 10_000_000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK         = 4'b1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] repeat_pulse,
    output logic [NUM_BTN-1:0] act_pulse
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // One repeat counter serves both the initial delay and the repeat period.
    localparam int unsigned REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                      REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int unsigned RC_W    = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RC_W-1:0] RR_LAST = RC_W'(REPEAT_RATE_CYCLES - 1);

    typedef enum logic [1:0] {
        REP_IDLE,
        REP_DELAY,
        REP_REPEAT
    } rep_state_e;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan

        localparam bit REP_EN = REPEAT_MASK[g];

        logic [1:0]      r_sync;
        logic [DB_W-1:0] r_db_cnt;
        logic            r_level;
        logic            r_press;
        logic            r_release;
        logic            w_sample;
        logic            w_differs;
        logic            w_db_done;
        logic            w_press_evt;
        logic            w_release_evt;

        rep_state_e      r_state;
        rep_state_e      w_state_nxt;
        logic [RC_W-1:0] r_rep_cnt;
        logic [RC_W-1:0] w_rep_cnt_nxt;
        logic            r_repeat;
        logic            w_repeat_nxt;

        // Bring the asynchronous button into the clock domain (s1 -> s2).
        always_ff @(posedge clock) begin
            if (reset) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[0], btn_in[g]};
            end
        end

        assign w_sample      = r_sync[1];
        assign w_differs     = (w_sample != r_level);
        assign w_db_done     = w_differs && (r_db_cnt == DB_LAST);
        // Edge events are decided one cycle before the registered pulses
        // appear, so the repeat FSM can start counting in the pulse cycle.
        assign w_press_evt   = w_db_done && w_sample;
        assign w_release_evt = w_db_done && !w_sample;

        // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_db_cnt  <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= w_press_evt;
                r_release <= w_release_evt;
                if (!w_differs) begin
                    r_db_cnt <= '0;
                end else if (w_db_done) begin
                    r_db_cnt <= '0;
                    r_level  <= w_sample;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end

        // Repeat FSM state, counter and registered repeat pulse.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_state   <= REP_IDLE;
                r_rep_cnt <= '0;
                r_repeat  <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_rep_cnt <= w_rep_cnt_nxt;
                r_repeat  <= w_repeat_nxt;
            end
        end

        // Repeat FSM next state: a release always wins over an expiring counter.
        always_comb begin
            w_state_nxt   = r_state;
            w_rep_cnt_nxt = r_rep_cnt;
            w_repeat_nxt  = 1'b0;
            if (!REP_EN || w_release_evt) begin
                w_state_nxt   = REP_IDLE;
                w_rep_cnt_nxt = '0;
            end else begin
                case (r_state)
                    REP_IDLE: begin
                        if (w_press_evt) begin
                            w_state_nxt   = REP_DELAY;
                            w_rep_cnt_nxt = '0;
                        end
                    end
                    REP_DELAY: begin
                        if (r_rep_cnt == RD_LAST) begin
                            w_state_nxt   = REP_REPEAT;
                            w_rep_cnt_nxt = '0;
                            w_repeat_nxt  = 1'b1;
                        end else begin
                            w_rep_cnt_nxt = r_rep_cnt + 1'b1;
                        end
                    end
                    REP_REPEAT: begin
                        if (r_rep_cnt == RR_LAST) begin
                            w_rep_cnt_nxt = '0;
                            w_repeat_nxt  = 1'b1;
                        end else begin
                            w_rep_cnt_nxt = r_rep_cnt + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt   = REP_IDLE;
                        w_rep_cnt_nxt = '0;
                    end
                endcase
            end
        end

        assign btn_level[g]     = r_level;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_release;
        assign repeat_pulse[g]  = r_repeat;
    end

    assign act_pulse = press_pulse | repeat_pulse;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Conditions the raw front-panel push-buttons (alarm reset, snooze, set, inc) before they reach the clock/alarm top level. Per channel it provides a 2-FF synchronizer, a counter-based debouncer, single-cycle press/release pulses, and an optional hold-to-auto-repeat pulse train. The top level consumes `act_pulse` for time setting, so holding "inc" scrolls hours and minutes.

Parameters:
- NUM_BTN, 4: number of independent button channels.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples required to accept a new level (10 ms at 100 MHz). Must be at least 2.
- REPEAT_DELAY_CYCLES, 50_000_000: cycles from `press_pulse` to the first `repeat_pulse` (0.5 s).
- REPEAT_RATE_CYCLES, 10_000_000: cycles between successive `repeat_pulse`s while held (0.1 s).
- REPEAT_MASK, 4'b1000: bit i = 1 enables auto-repeat on channel i.

Ports:
- `clock`, input, 1: system clock, 100 MHz.
- `reset`, input, 1: synchronous, active-high.
- `btn_in`, input, NUM_BTN: raw asynchronous active-high buttons.
- `btn_level`, output, NUM_BTN: debounced level.
- `press_pulse`, output, NUM_BTN: 1-cycle pulse on each debounced 0->1 transition.
- `release_pulse`, output, NUM_BTN: 1-cycle pulse on each debounced 1->0 transition.
- `repeat_pulse`, output, NUM_BTN: 1-cycle auto-repeat pulse.
- `act_pulse`, output, NUM_BTN: `press_pulse | repeat_pulse`.

Behaviour:
- Interface: reset `reset`, synchronous, active-high; clock `clock`.
- Reset value: all sync flops, counters and outputs are 0; every repeat FSM is in IDLE.
- Channels are fully independent. There is no cross-channel priority.
- Sync: `btn_in[i]` -> s1 -> s2. s2 is the sampled value.
- Debounce counter:
  - Width is `$clog2(DEBOUNCE_CYCLES)`.
  - Cleared on any cycle where s2 == `btn_level`.
  - Incremented on each cycle where s2 != `btn_level`.
  - When the counter == DEBOUNCE_CYCLES-1 and s2 != `btn_level`: on that edge `btn_level` <= s2 and the counter is cleared.
- Latency: a clean raw edge reaches `btn_level` DEBOUNCE_CYCLES+2 cycles later.
- Glitches: any glitch shorter than DEBOUNCE_CYCLES samples produces no output change.
- `press_pulse` / `release_pulse` are registered and high in the same cycle `btn_level` first shows the new value. Each is exactly 1 cycle wide.
- Repeat FSM (per channel, only if REPEAT_MASK[i] = 1; otherwise the channel is held in IDLE and `repeat_pulse[i]` = 0):
  - IDLE: on a press event -> DELAY, rep_cnt <= 0.
  - DELAY: rep_cnt increments. When rep_cnt == REPEAT_DELAY_CYCLES-1, the next cycle drives `repeat_pulse` = 1 and the FSM goes to REPEAT with rep_cnt <= 0. The first repeat pulse is therefore exactly REPEAT_DELAY_CYCLES cycles after `press_pulse`.
  - REPEAT: `repeat_pulse` = 1 every REPEAT_RATE_CYCLES cycles. The counter wraps to 0 after each pulse.
  - Any state, release event: -> IDLE, rep_cnt <= 0. No `repeat_pulse` is issued in the release cycle, even if the counter expires that cycle; release wins.
- rep_cnt width is `$clog2(max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES))`.
- `press_pulse` and `repeat_pulse` are never high in the same cycle on one channel.
- Reset mid-operation clears everything. A button still held after reset deassertion is re-detected as a fresh press: `press_pulse` fires DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- Button held across power-up: treated identically to the reset case above.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=5 and REPEAT_MASK=4'b1000. Cycle numbers are relative to the raw edge at cycle 0.

1. Clean press on ch0: `btn_in[0]` rises at cycle 0 and is held -> `btn_level[0]` = 1 and `press_pulse[0]` = 1 at cycle 10 only. `repeat_pulse[0]` stays 0 (masked).
2. Bounce on ch1: the input toggles every 3 cycles for cycles 0-29, then is stable high from cycle 30 -> no outputs before cycle 40. Exactly one `press_pulse[1]`, at cycle 40.
3. Auto-repeat on ch3: rise at cycle 0, fall at cycle 60 ->
   - `press_pulse` at 10;
   - `repeat_pulse` at 30, 35, 40, 45, 50, 55, 60, 65 (8 pulses);
   - `release_pulse` at 70 with no repeat at 70;
   - `act_pulse` = 9 pulses total.
4. Glitch rejection: 5-cycle high pulse on ch2 -> all ch2 outputs remain 0 throughout.
5. Reset mid-hold on ch3: hold from cycle 0, assert `reset` during cycles 40-41 ->
   - all outputs 0 at cycle 41;
   - next `press_pulse[3]` at cycle 52;
   - first repeat at cycle 72.
6. Simultaneous ch0 and ch3 presses at cycle 0 -> both `press_pulse` bits high at cycle 10. ch3 repeats as in scenario 3 and ch0 is unaffected.
